// File: rtl/piece_queue_if.sv
// piece_queue_if: connection between the 7-bag piece queue and its consumers
// (the spawn FSM and the preview renderer).
//   take       : spawn request from the game FSM (level)
//   head_piece : piece type at slot 0 (0=I 1=O 2=T 3=S 4=Z 5=J 6=L)
//   head_valid : queue holds at least one piece
//   preview    : slots 1..DEPTH-1, slot k at bits [3k-1:3k-3]
//   count      : occupied slots, 0..DEPTH
//   bag_mask   : types already drawn from the current bag
// Modports: master = game side (drives take), slave = queue side.
interface piece_queue_if #(
  parameter int DEPTH = 4
);
  logic                   take;
  logic [2:0]             head_piece;
  logic                   head_valid;
  logic [3*(DEPTH-1)-1:0] preview;
  logic [2:0]             count;
  logic [6:0]             bag_mask;

  modport master (
    output take,
    input  head_piece, head_valid, preview, count, bag_mask
  );

  modport slave (
    input  take,
    output head_piece, head_valid, preview, count, bag_mask
  );
endinterface

// File: rtl/piece_queue.sv
// piece_queue: turns the free-running LFSR value into a 7-bag tetromino
// stream and buffers DEPTH pieces (head + preview).
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rand_data : LFSR output, only bits [2:0] are used as the candidate type
//   q         : piece_queue_if slave (take in; head/preview/count/mask out)
// One draw attempt per cycle while there is room. A candidate already in the
// bag (or the unused code 7) is rejected; after REJECT_LIMIT consecutive
// attempts the lowest free type is taken so a refill is always bounded.
module piece_queue #(
  parameter int DEPTH        = 4,
  parameter int REJECT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rand_data,
  piece_queue_if.slave q
);

  logic [2:0] slot [DEPTH];
  logic [2:0] count_r;
  logic [6:0] mask_r;
  logic [4:0] rej_r;

  logic [2:0] slot_n [DEPTH];
  logic [2:0] count_n;
  logic [6:0] mask_n;
  logic [4:0] rej_n;

  logic       take_acc;
  logic       space;
  logic [2:0] cand;
  logic       cand_ok;
  logic       accept;
  logic [2:0] piece;
  logic [2:0] wr_idx;
  logic [7:0] mask_ext;
  logic [6:0] mask_sum;
  logic [3*(DEPTH-1)-1:0] preview_v;

  // Lowest type not yet drawn from the bag; the bag mask is never all ones
  // at the register output, so a free type always exists.
  function automatic logic [2:0] lowest_free(input logic [6:0] m);
    lowest_free = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!m[i]) lowest_free = 3'(i);
    end
  endfunction

  // Draw decision
  always_comb begin
    take_acc = q.take & (count_r != 3'd0);
    space    = (count_r < 3'(DEPTH)) | take_acc;
    cand     = rand_data[2:0];
    // Bit 7 set marks code 7 as permanently unusable.
    mask_ext = {1'b1, mask_r};
    cand_ok  = !mask_ext[cand];
    accept   = space & (cand_ok | (rej_r == 5'(REJECT_LIMIT - 1)));
    piece    = cand_ok ? cand : lowest_free(mask_r);
    wr_idx   = count_r - {2'b00, take_acc};
  end

  // Next state
  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot_n[k] = slot[k];
    count_n = count_r - {2'b00, take_acc} + {2'b00, accept};
    mask_n  = mask_r;
    rej_n   = rej_r;
    mask_sum = mask_r | (7'b1 << piece);

    if (take_acc) begin
      for (int k = 0; k < DEPTH - 1; k++) slot_n[k] = slot[k+1];
      slot_n[DEPTH-1] = 3'd0;
    end

    // Write after the shift so a same-cycle take/accept lands one slot lower.
    if (accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_idx == 3'(k)) slot_n[k] = piece;
      end
      mask_n = (mask_sum == 7'h7F) ? 7'h00 : mask_sum;
    end

    if (space) rej_n = accept ? 5'd0 : rej_r + 5'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= 3'd0;
      count_r <= 3'd0;
      mask_r  <= 7'd0;
      rej_r   <= 5'd0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= slot_n[k];
      count_r <= count_n;
      mask_r  <= mask_n;
      rej_r   <= rej_n;
    end
  end

  // Outputs straight from registers
  always_comb begin
    preview_v = '0;
    for (int k = 1; k < DEPTH; k++) preview_v[3*k-1 -: 3] = slot[k];
  end

  assign q.head_piece = slot[0];
  assign q.head_valid = (count_r != 3'd0);
  assign q.preview    = preview_v;
  assign q.count      = count_r;
  assign q.bag_mask   = mask_r;

endmodule
